demux1an_rr: RTL

Parametrised 1-to-N round-robin demultiplexer for the receive path, successor of the fixed 1-to-2, 4-bit demux. Each accepted input word goes to the next lane in strict rotation (lane 0 first). Each lane's output is registered, with a per-lane valid and a frame strobe when a full set of N words has been distributed. It sits after the serial-to-parallel stage and feeds per-lane FIFOs.

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux1an_lane.sv | 40 ++++
 rtl/demux1an_rr.sv | 90 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N round-robin receive demultiplexer:
// legal lane-count bounds, pointer-width helper and the lane pointer type.
package demux_pkg;

    localparam int DEMUX_LANES_MIN = 2;
    localparam int DEMUX_LANES_MAX = 16;

    // Widest pointer ever needed (DEMUX_LANES_MAX lanes).
    localparam int DEMUX_SEL_W_MAX = 4;

    // Pointer width for a given lane count; never narrower than one bit.
    function automatic int sel_width(input int lanes);
        return (lanes > 2) ? $clog2(lanes) : 1;
    endfunction

    // Lane pointer wide enough for any legal lane count; used for lane matching.
    typedef logic [DEMUX_SEL_W_MAX-1:0] lane_ptr_t;

endpackage

// File: rtl/demux1an_lane.sv
// One output lane: WIDTH-bit data register plus one-cycle valid flag.
// Build option DEMUX1AN_HOLD_EN: when defined, the lane holds its last word
// while not written; when undefined, it clears to zero on every unwritten cycle.
module demux1an_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);

    logic [WIDTH-1:0] data_reg;
    logic             vld_reg;

    // Capture the word on a write; otherwise hold or clear depending on build.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            data_reg <= '0;
            vld_reg  <= 1'b0;
        end else begin
            vld_reg <= wr_en;
            if (wr_en) begin
                data_reg <= din;
            end else begin
`ifdef DEMUX1AN_HOLD_EN
                data_reg <= data_reg;
`else
                data_reg <= '0;
`endif
            end
        end
    end

    assign dout = data_reg;
    assign vld  = vld_reg;

endmodule

// File: rtl/demux1an_rr.sv
// 1-to-LANES round-robin demultiplexer. Each accepted word goes to the lane
// named by the rotation pointer, which wraps at LANES-1 (non-power-of-two
// safe). align restarts the rotation at lane 0, dropping any partial frame.
// Lane hold/clear behaviour is selected by the DEMUX1AN_HOLD_EN define.
module demux1an_rr
    import demux_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int LANES = 2,
    localparam int SELW  = sel_width(LANES)
) (
    input  logic                   clk_2f,
    input  logic                   reset_L,
    input  logic                   valid_in,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   align,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   frame_valid,
    output logic [SELW-1:0]        lane_sel
);

    generate
        if (LANES < DEMUX_LANES_MIN || LANES > DEMUX_LANES_MAX || WIDTH < 1) begin : g_bad_cfg
            $fatal(1, "demux1an_rr: LANES must be 2..16 and WIDTH >= 1");
        end
    endgenerate

    localparam logic [SELW-1:0] LAST_SEL = SELW'(LANES - 1);

    logic [SELW-1:0]  sel_reg;
    logic [SELW-1:0]  sel_next;
    logic             frame_reg;
    logic             frame_next;
    logic [LANES-1:0] lane_wr;

    // Next pointer and frame strobe: align forces lane 0; a word closes a
    // frame only when it lands in the last lane without a realign.
    always_comb begin
        sel_next   = sel_reg;
        frame_next = 1'b0;
        if (valid_in) begin
            if (align) begin
                sel_next = SELW'(1);
            end else if (sel_reg == LAST_SEL) begin
                sel_next = '0;
            end else begin
                sel_next = sel_reg + 1'b1;
            end
            frame_next = !align && (sel_reg == LAST_SEL);
        end else if (align) begin
            sel_next = '0;
        end
    end

    // Rotation pointer and frame strobe registers.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            sel_reg   <= '0;
            frame_reg <= 1'b0;
        end else begin
            sel_reg   <= sel_next;
            frame_reg <= frame_next;
        end
    end

    // One lane per output; at most one write enable is high per cycle.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam bit IS_FIRST = (gi == 0);

        assign lane_wr[gi] = valid_in &&
                             (align ? IS_FIRST
                                    : (lane_ptr_t'(sel_reg) == lane_ptr_t'(gi)));

        demux1an_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk_2f  (clk_2f),
            .reset_L (reset_L),
            .wr_en   (lane_wr[gi]),
            .din     (data_in),
            .dout    (data_out[gi*WIDTH +: WIDTH]),
            .vld     (valid_out[gi])
        );
    end

    assign frame_valid = frame_reg;
    assign lane_sel    = sel_reg;

endmodule
